// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets and console FIFO depth.
package dmem_pkg;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic [11:0] OFF_LED     = 12'h000;
  localparam logic [11:0] OFF_CONSOLE = 12'h004;
  localparam logic [11:0] OFF_CYCLE   = 12'h008;

  localparam int CONSOLE_DEPTH = 4;

endpackage

// File: rtl/console_fifo.sv
// Byte console FIFO: 4x8 register storage, sticky overflow on a dropped push,
// and a head byte presented over a valid/ready handshake.
module console_fifo
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  input  logic       clear_overflow,
  output logic [7:0] head,
  output logic       valid,
  output logic [2:0] count,
  output logic       full,
  output logic       overflow
);

  localparam int PW = $clog2(CONSOLE_DEPTH);

  logic [7:0]    mem [CONSOLE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop;
  logic          push_ok;

  assign valid   = (count != 3'd0);
  assign full    = (count == 3'(CONSOLE_DEPTH));
  assign pop     = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop);
  assign head    = valid ? mem[rd_ptr] : 8'h00;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
      if (clear_overflow)             overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; head is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core: word-organised local RAM with byte-lane
// stores and zero-latency loads, plus an MMIO page (LED, console, cycle counter).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [1:0]  mask,
  input  logic        dmem_wen,
  output logic [31:0] dmem_rdata,
  output logic [15:0] led,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic          ram_hit;
  logic          mmio_hit;
  logic [11:0]   off;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   mmio_rdata;
  logic          mmio_wr;
  logic          con_wr;
  logic          cyc_clear;
  logic [31:0]   cycle;
  logic [2:0]    con_count;
  logic          con_full;
  logic          con_ovf;

  assign ram_hit  = {1'b0, dmem_addr} < (33'(DEPTH_WORDS) << 2);
  assign mmio_hit = (dmem_addr[31:12] == MMIO_BASE[31:12]);
  assign off      = dmem_addr[11:0];
  assign word_idx = dmem_addr[AW+1:2];

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = dmem_wdata;
    case (mask)
      MASK_B: begin
        lane_wdata = {4{dmem_wdata[7:0]}};
        lane_we    = 4'b0001 << dmem_addr[1:0];
      end
      MASK_H: begin
        lane_wdata = {2{dmem_wdata[15:0]}};
        if (!dmem_addr[0]) lane_we = dmem_addr[1] ? 4'b1100 : 4'b0011;
      end
      MASK_W: begin
        if (dmem_addr[1:0] == 2'b00) lane_we = 4'b1111;
      end
      default: lane_we = 4'b0000;
    endcase
    if (!(dmem_wen && ram_hit)) lane_we = 4'b0000;
  end

  // NOTE: the RAM array has no reset; only control state is cleared by rst_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) ram[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
    end
  end

  assign ram_rdata = ram[word_idx] >> {dmem_addr[1:0], 3'b000};

  // MMIO writes are honoured only as full-word accesses.
  assign mmio_wr   = dmem_wen && mmio_hit && (mask == MASK_W);
  assign con_wr    = mmio_wr && (off == OFF_CONSOLE);
  assign cyc_clear = mmio_wr && (off == OFF_CYCLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led   <= 16'h0000;
      cycle <= 32'h0000_0000;
    end else begin
      if (mmio_wr && (off == OFF_LED)) led <= dmem_wdata[15:0];
      cycle <= cyc_clear ? 32'h0000_0000 : cycle + 32'd1;
    end
  end

  console_fifo u_console (
    .clk            (clk),
    .rst_n          (rst_n),
    .push           (con_wr && !dmem_wdata[31]),
    .push_data      (dmem_wdata[7:0]),
    .ready          (console_ready),
    .clear_overflow (con_wr && dmem_wdata[31]),
    .head           (console_data),
    .valid          (console_valid),
    .count          (con_count),
    .full           (con_full),
    .overflow       (con_ovf)
  );

  always_comb begin
    case (off)
      OFF_LED:     mmio_rdata = {16'h0000, led};
      OFF_CONSOLE: mmio_rdata = {27'b0, con_ovf, con_full, con_count};
      OFF_CYCLE:   mmio_rdata = cycle;
      default:     mmio_rdata = 32'h0000_0000;
    endcase
    dmem_rdata = 32'h0000_0000;
    if (ram_hit)       dmem_rdata = ram_rdata;
    else if (mmio_hit) dmem_rdata = mmio_rdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-level memory/queue model
// checked every cycle, plus hand-computed literal expectations.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] MB    = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [1:0]  mask;
  logic        dmem_wen;
  logic [31:0] dmem_rdata;
  logic [15:0] led;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .INIT_FILE(""), .MMIO_BASE(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .mask          (mask),
    .dmem_wen      (dmem_wen),
    .dmem_rdata    (dmem_rdata),
    .led           (led),
    .console_data  (console_data),
    .console_valid (console_valid),
    .console_ready (console_ready)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: byte-addressed RAM, byte queue for the console.
  logic [7:0]  m_mem [int unsigned];
  logic [15:0] m_led;
  logic [31:0] m_cyc;
  logic [7:0]  q[$];
  logic        m_ovf;
  bit          cmp_en = 1'b0;
  bit          chk_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    int unsigned base;
    if (a < 4 * DEPTH) begin
      base = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++)
        w[8*i +: 8] = m_mem.exists(base + i) ? m_mem[base + i] : 8'hxx;
      return w >> (8 * a[1:0]);
    end
    if (a[31:12] == MB[31:12]) begin
      case (a[11:0])
        12'h000: return {16'h0000, m_led};
        12'h004: return {27'b0, m_ovf, q.size() == 4, 3'(q.size())};
        12'h008: return m_cyc;
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_led = 16'h0;
    m_cyc = 32'h0;
    m_ovf = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_update();
    int   sz = q.size();
    bit   pop = (sz > 0) && console_ready;
    bit   mw = dmem_wen && (dmem_addr[31:12] == MB[31:12]) && (mask == 2'b10);
    logic [11:0] o = dmem_addr[11:0];
    int unsigned a = dmem_addr;
    if (pop) void'(q.pop_front());
    if (mw && o == 12'h004) begin
      if (dmem_wdata[31])       m_ovf = 1'b0;
      else if (sz < 4 || pop)   q.push_back(dmem_wdata[7:0]);
      else                      m_ovf = 1'b1;
    end
    m_cyc = (mw && o == 12'h008) ? 32'h0 : m_cyc + 32'd1;
    if (mw && o == 12'h000) m_led = dmem_wdata[15:0];
    if (dmem_wen && a < 4 * DEPTH) begin
      case (mask)
        2'b00: m_mem[a] = dmem_wdata[7:0];
        2'b01: if (a % 2 == 0) begin
          m_mem[a] = dmem_wdata[7:0];
          m_mem[a + 1] = dmem_wdata[15:8];
        end
        2'b10: if (a % 4 == 0)
          for (int i = 0; i < 4; i++) m_mem[a + i] = dmem_wdata[8*i +: 8];
        default: ;
      endcase
    end
  endtask

  // Compare process: outputs against the model every cycle away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("led", {16'h0, led}, {16'h0, m_led});
      check("console_valid", {31'h0, console_valid}, {31'h0, q.size() != 0});
      check("console_data", {24'h0, console_data}, {24'h0, (q.size() != 0) ? q[0] : 8'h00});
      if (chk_rd) check("rdata", dmem_rdata, model_read(dmem_addr));
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [1:0] m,
                       input logic we, input logic rdy, input bit rd);
    dmem_addr     = a;
    dmem_wdata    = w;
    mask          = m;
    dmem_wen      = we;
    console_ready = rdy;
    chk_rd        = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] w, input logic [1:0] m,
                      input logic we, input logic rdy);
    drive(a, w, m, we, rdy, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_valid", {31'h0, console_valid}, 32'h0);
    check("reset_data", {24'h0, console_data}, 32'h0);
    check("reset_cycle", dmem_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Counter reads 0 in the first cycle after release, then 1.
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("cycle_release0", dmem_rdata, 32'h0);
    tick();
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("cycle_release1", dmem_rdata, 32'h1);
    tick();

    // Byte-lane stores.
    drive(32'h10, 32'h1122_3344, MASK_W, 1'b1, 1'b0, 1'b0); tick();
    step(32'h13, 32'h0000_00AA, MASK_B, 1'b1, 1'b0);
    step(32'h10, 32'h0000_BEEF, MASK_H, 1'b1, 1'b0);
    drive(32'h10, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("word_after_lanes", dmem_rdata, 32'hAA22_BEEF);
    tick();
    drive(32'h13, 32'h0, MASK_B, 1'b0, 1'b0, 1'b1); #1;
    check("byte_load_13", dmem_rdata, 32'h0000_00AA);
    tick();

    // Misaligned, reserved and unmapped accesses.
    step(32'h11, 32'h0000_1234, MASK_H, 1'b1, 1'b0);
    step(32'h12, 32'hDEAD_BEEF, MASK_W, 1'b1, 1'b0);
    step(32'h10, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b0);
    step(32'h8000_0000, 32'h5555_5555, MASK_W, 1'b1, 1'b0);
    drive(32'h10, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("word_unchanged", dmem_rdata, 32'hAA22_BEEF);
    tick();
    drive(32'h8000_0000, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("unmapped_read", dmem_rdata, 32'h0);
    tick();

    // LED register.
    step(MB, 32'h1234_00FF, MASK_W, 1'b1, 1'b0);
    drive(MB, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("led_read", dmem_rdata, 32'h0000_00FF);
    tick();

    // Console backpressure and overflow.
    for (int i = 0; i < 5; i++) step(MB + 32'h4, 32'h41 + i, MASK_W, 1'b1, 1'b0);
    drive(MB + 32'h4, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("status_overflow", dmem_rdata, 32'h0000_001C);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(MB + 32'h4, 32'h0, MASK_W, 1'b0, 1'b1, 1'b1); #1;
      check("drain_order", {24'h0, console_data}, 32'h41 + i);
      tick();
    end
    check("drain_empty", {31'h0, console_valid}, 32'h0);

    // Full FIFO with simultaneous push and pop.
    step(MB + 32'h4, 32'h8000_0000, MASK_W, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(MB + 32'h4, 32'h50 + i, MASK_W, 1'b1, 1'b0);
    step(MB + 32'h4, 32'h54, MASK_W, 1'b1, 1'b1);
    drive(MB + 32'h4, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("status_full_no_ovf", dmem_rdata, 32'h0000_000C);
    tick();
    for (int i = 0; i < 4; i++) step(MB + 32'h4, 32'h0, MASK_W, 1'b0, 1'b1);

    // Push into empty: valid rises exactly one cycle later.
    drive(MB + 32'h4, 32'h60, MASK_W, 1'b1, 1'b0, 1'b1); #1;
    check("push_empty_same", {31'h0, console_valid}, 32'h0);
    tick();
    check("push_empty_next", {31'h0, console_valid}, 32'h1);
    check("push_empty_data", {24'h0, console_data}, 32'h60);
    step(MB + 32'h4, 32'h0, MASK_W, 1'b0, 1'b1);

    // Cycle counter clear and wrap.
    step(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0);
    step(MB + 32'h8, 32'h1234, MASK_W, 1'b1, 1'b0);
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("cycle_cleared", dmem_rdata, 32'h0);
    tick();
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("cycle_two_later", dmem_rdata, 32'h1);
    tick();
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1);
    force dut.cycle = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #2 release dut.cycle;
    tick();
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b0, 1'b1); #1;
    check("cycle_wrap", dmem_rdata, 32'h0);
    tick();

    // Reset mid-drain with LED set.
    step(MB, 32'h0000_00FF, MASK_W, 1'b1, 1'b0);
    step(MB + 32'h4, 32'h70, MASK_W, 1'b1, 1'b0);
    step(MB + 32'h4, 32'h71, MASK_W, 1'b1, 1'b0);
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b1, 1'b1);
    @(negedge clk); #1;
    rst_n  = 1'b0;
    cmp_en = 1'b0;
    #1;
    check("async_reset_led", {16'h0, led}, 32'h0);
    check("async_reset_valid", {31'h0, console_valid}, 32'h0);
    check("async_reset_cycle", dmem_rdata, 32'h0);
    drive(32'h10, 32'h0, MASK_W, 1'b0, 1'b1, 1'b0); #1;
    check("ram_survives_reset", dmem_rdata, 32'hAA22_BEEF);
    model_reset();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    drive(MB + 32'h8, 32'h0, MASK_W, 1'b0, 1'b1, 1'b1); #1;
    check("cycle_after_rerelease", dmem_rdata, 32'h0);
    tick();
    step(MB + 32'h4, 32'h0, MASK_W, 1'b0, 1'b1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
